// File: rtl/key_debounce_pkg.sv
// Shared types for the multi-channel key debouncer: channel FSM states, db_out shaping modes
// and the counter-width helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  typedef enum logic [1:0] {
    MODE_PULSE,
    MODE_HOLD,
    MODE_LEVEL
  } db_mode_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: input synchronizer, press/release FSM, column capture at press
// acceptance and db_out shaping.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int unsigned COL_W         = 4,
  parameter int unsigned STABLE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES   = 2700000,
  parameter db_mode_e    MODE          = MODE_HOLD
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             button_i,
  input  logic [COL_W-1:0] columnas_i,
  output logic             db_level_o,
  output logic             db_out_o,
  output logic             accept_o,
  output logic [COL_W-1:0] col_o
);

  localparam int unsigned CntW  = cnt_width(STABLE_CYCLES);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

  logic [1:0]       sync_q;
  logic             sample;
  db_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [HoldW-1:0] hold_q;
  logic             level_q;
  logic             accept_q;
  logic             db_out_q;
  logic [COL_W-1:0] col_q;
  logic             accept_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], button_i};
    end
  end

  assign sample = sync_q[1];

  // The transition into PRESSED happens on the edge where the count would reach STABLE_CYCLES.
  assign accept_d = (state_q == PRESS_WAIT) && sample && (cnt_q == CntLast);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      accept_q <= 1'b0;
      col_q    <= '0;
    end else begin
      accept_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CntW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sample) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (accept_d) begin
            state_q  <= PRESSED;
            cnt_q    <= '0;
            level_q  <= 1'b1;
            accept_q <= 1'b1;
            col_q    <= columnas_i;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sample) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CntW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sample) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  // Hold counter runs 1..HOLD_CYCLES while db_out_q is high and then parks at its maximum.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      db_out_q <= 1'b0;
      hold_q   <= '0;
    end else if (MODE == MODE_PULSE) begin
      db_out_q <= accept_d;
    end else if (accept_d) begin
      db_out_q <= 1'b1;
      hold_q   <= HoldW'(1);
    end else if (db_out_q) begin
      if (hold_q == HoldMax) begin
        db_out_q <= 1'b0;
      end else begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign db_level_o = level_q;
  assign db_out_o   = (MODE == MODE_LEVEL) ? level_q : db_out_q;
  assign accept_o   = accept_q;
  assign col_o      = col_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: per-channel debounce, pending press flags, fixed-priority
// arbiter feeding a valid/ready event register, and a sticky lost-event flag.
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned COL_W         = 4,
  parameter int unsigned STABLE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES   = 2700000,
  parameter db_mode_e    MODE          = MODE_HOLD,
  localparam int unsigned CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       button_in,
  input  logic [COL_W-1:0]          columnas,
  output logic [CHANNELS-1:0]       db_level,
  output logic [CHANNELS-1:0]       db_out,
  output logic [CHANNELS*COL_W-1:0] col_latched,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [CHAN_W-1:0]         evt_chan,
  output logic [COL_W-1:0]          evt_col,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic                evt_valid_q, evt_valid_d;
  logic [CHAN_W-1:0]   evt_chan_q, evt_chan_d;
  logic [COL_W-1:0]    evt_col_q, evt_col_d;
  logic                overflow_q, overflow_d;
  logic                load;
  logic                sel_found;
  logic [CHAN_W-1:0]   sel_idx;
  logic                new_ovf;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .COL_W         (COL_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .MODE          (MODE)
    ) u_chan (
      .clk_i      (clk),
      .reset_i    (reset),
      .button_i   (button_in[g]),
      .columnas_i (columnas),
      .db_level_o (db_level[g]),
      .db_out_o   (db_out[g]),
      .accept_o   (accept[g]),
      .col_o      (col_latched[g*COL_W +: COL_W])
    );
  end

  // Lowest index wins: scan downward so the last hit is the smallest pending channel.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = CHAN_W'(i);
      end
    end
  end

  always_comb begin
    load        = !evt_valid_q || evt_ready;
    pending_d   = pending_q;
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    evt_col_d   = evt_col_q;
    new_ovf     = 1'b0;
    if (load) begin
      evt_valid_d = sel_found;
      if (sel_found) begin
        evt_chan_d         = sel_idx;
        evt_col_d          = col_latched[sel_idx*COL_W +: COL_W];
        pending_d[sel_idx] = 1'b0;
      end
    end
    // Checked after the load clears its bit, so a press landing on its own load is not lost.
    for (int i = 0; i < CHANNELS; i++) begin
      if (accept[i]) begin
        if (pending_d[i]) begin
          new_ovf = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
    end
    if (new_ovf) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      evt_col_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      evt_col_q   <= evt_col_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_chan  = evt_chan_q;
  assign evt_col   = evt_col_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: three instances (hold, pulse, level) share one stimulus.
module tb_key_debounce_multi;
  import key_debounce_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned ST = 6;
  localparam int unsigned HD = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] button_in = '0;
  logic [CW-1:0] columnas = '0;
  logic          evt_ready = 1'b0;
  logic          clear_overflow = 1'b0;

  logic [CH-1:0]    lvl_h, out_h, lvl_p, out_p, lvl_l, out_l;
  logic [CH*CW-1:0] col_h, col_p, col_l;
  logic             v_h, v_p, v_l;
  logic [1:0]       ch_h, ch_p, ch_l;
  logic [CW-1:0]    ec_h, ec_p, ec_l;
  logic             of_h, of_p, of_l;

  key_debounce_multi #(
    .CHANNELS(CH), .COL_W(CW), .STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .MODE(MODE_HOLD)
  ) u_hold (
    .clk(clk), .reset(reset), .button_in(button_in), .columnas(columnas),
    .db_level(lvl_h), .db_out(out_h), .col_latched(col_h), .evt_valid(v_h),
    .evt_ready(evt_ready), .evt_chan(ch_h), .evt_col(ec_h), .overflow(of_h),
    .clear_overflow(clear_overflow)
  );

  key_debounce_multi #(
    .CHANNELS(CH), .COL_W(CW), .STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .MODE(MODE_PULSE)
  ) u_pulse (
    .clk(clk), .reset(reset), .button_in(button_in), .columnas(columnas),
    .db_level(lvl_p), .db_out(out_p), .col_latched(col_p), .evt_valid(v_p),
    .evt_ready(evt_ready), .evt_chan(ch_p), .evt_col(ec_p), .overflow(of_p),
    .clear_overflow(clear_overflow)
  );

  key_debounce_multi #(
    .CHANNELS(CH), .COL_W(CW), .STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .MODE(MODE_LEVEL)
  ) u_level (
    .clk(clk), .reset(reset), .button_in(button_in), .columnas(columnas),
    .db_level(lvl_l), .db_out(out_l), .col_latched(col_l), .evt_valid(v_l),
    .evt_ready(evt_ready), .evt_chan(ch_l), .evt_col(ec_l), .overflow(of_l),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input int ch);
    button_in[ch] = 1'b1;
    tick(8);
    button_in[ch] = 1'b0;
    tick(12);
  endtask

  typedef struct {
    int            ch;
    logic [CW-1:0] col_press;
    logic [CW-1:0] col_after;
    logic [CW-1:0] exp_col;
    logic [1:0]    exp_chan;
    int            exp_rise;
    int            exp_hold;
    int            exp_pulse;
  } press_vec_t;

  press_vec_t vecs[3];

  initial begin
    int rise, hold_hi, pulse_hi, lvl_err, err;

    // Rise is ST+2 ticks after the button goes high; hold lasts HD cycles, pulse one.
    vecs[0] = '{0, 4'b0010, 4'b0010, 4'b0010, 2'd0, 8, 20, 1};
    vecs[1] = '{2, 4'b0100, 4'b1000, 4'b0100, 2'd2, 8, 20, 1};
    vecs[2] = '{3, 4'b1111, 4'b0000, 4'b1111, 2'd3, 8, 20, 1};

    reset = 1'b1;
    tick(2);
    chk("rst_level", {lvl_h, lvl_p, lvl_l}, '0);
    chk("rst_out", {out_h, out_p, out_l}, '0);
    chk("rst_col", {col_h, col_p, col_l}, '0);
    chk("rst_evt", {v_h, v_p, v_l, ch_h, ch_p, ch_l, ec_h, ec_p, ec_l}, '0);
    chk("rst_ovf", {of_h, of_p, of_l}, '0);
    reset = 1'b0;
    tick(2);

    for (int k = 0; k < 3; k++) begin
      columnas = vecs[k].col_press;
      button_in[vecs[k].ch] = 1'b1;
      rise = 0;
      for (int c = 1; c <= 40 && rise == 0; c++) begin
        tick();
        if (lvl_h[vecs[k].ch]) rise = c;
      end
      chk("rise_cycle", rise, vecs[k].exp_rise);
      chk("rise_outs", {out_h[vecs[k].ch], out_p[vecs[k].ch], out_l[vecs[k].ch]}, 3'b111);
      chk("col_at_press", col_h[vecs[k].ch*CW +: CW], vecs[k].exp_col);
      columnas = vecs[k].col_after;
      hold_hi  = int'(out_h[vecs[k].ch]);
      pulse_hi = int'(out_p[vecs[k].ch]);
      lvl_err  = 0;
      repeat (40) begin
        tick();
        hold_hi  += int'(out_h[vecs[k].ch]);
        pulse_hi += int'(out_p[vecs[k].ch]);
        if (out_l !== lvl_l) lvl_err++;
      end
      chk("hold_width", hold_hi, vecs[k].exp_hold);
      chk("pulse_width", pulse_hi, vecs[k].exp_pulse);
      chk("level_follow", lvl_err, 0);
      chk("level_stays", lvl_h[vecs[k].ch], 1'b1);
      chk("col_frozen", col_h[vecs[k].ch*CW +: CW], vecs[k].exp_col);
      chk("evt_valid", v_h, 1'b1);
      chk("evt_chan", ch_h, vecs[k].exp_chan);
      chk("evt_col", ec_h, vecs[k].exp_col);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk("evt_drained", {v_h, v_p, v_l}, 3'b000);
      button_in[vecs[k].ch] = 1'b0;
      tick(12);
      chk("released", {lvl_h, lvl_l, out_l}, '0);
    end

    // Bounce on ch1 never lasts long enough to be accepted.
    err = 0;
    for (int c = 0; c < 200; c++) begin
      button_in[1] = (c < 4) ? ((c % 2) == 0) : 1'b0;
      tick();
      if ((lvl_h | out_h | out_p | lvl_l) != '0 || v_h || v_p || v_l) err++;
    end
    chk("bounce_quiet", err, 0);

    // ch1 and ch3 accepted together; ch1 must be delivered first.
    button_in[1] = 1'b1;
    button_in[3] = 1'b1;
    tick(8);
    chk("simul_levels", {lvl_h[3], lvl_h[1]}, 2'b11);
    tick(2);
    chk("simul_first", {v_h, ch_h}, {1'b1, 2'd1});
    err = 0;
    repeat (5) begin
      tick();
      if (!v_h || ch_h !== 2'd1) err++;
    end
    chk("simul_stable", err, 0);
    evt_ready = 1'b1;
    tick();
    chk("simul_second", {v_h, ch_h}, {1'b1, 2'd3});
    tick();
    chk("simul_done", v_h, 1'b0);
    evt_ready = 1'b0;
    chk("simul_no_ovf", of_h, 1'b0);
    button_in[1] = 1'b0;
    button_in[3] = 1'b0;
    tick(12);

    // ch3 occupies the event register, so ch0's second press finds pending[0] still set.
    press_release(3);
    press_release(0);
    chk("ovf_first_press", of_h, 1'b0);
    press_release(0);
    chk("ovf_set", {of_h, of_p, of_l}, 3'b111);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", {of_h, of_p, of_l}, 3'b000);
    evt_ready = 1'b1;
    tick();
    chk("ovf_drain_ch0", {v_h, ch_h}, {1'b1, 2'd0});
    tick();
    chk("ovf_drain_done", v_h, 1'b0);
    evt_ready = 1'b0;

    // Reset in the middle of the hold window with an event waiting.
    columnas = 4'b0110;
    button_in[0] = 1'b1;
    tick(18);
    chk("pre_reset_busy", {out_h[0], v_h}, 2'b11);
    reset = 1'b1;
    button_in[0] = 1'b0;
    tick();
    chk("mid_rst_level", {lvl_h, lvl_p, lvl_l}, '0);
    chk("mid_rst_out", {out_h, out_p, out_l}, '0);
    chk("mid_rst_col", {col_h, col_p, col_l}, '0);
    chk("mid_rst_evt", {v_h, v_p, v_l, ch_h, ch_p, ch_l, ec_h, ec_p, ec_l, of_h, of_p, of_l}, '0);
    reset = 1'b0;
    err = 0;
    repeat (30) begin
      tick();
      if (v_h || v_p || v_l || (lvl_h | lvl_p | lvl_l) != '0) err++;
    end
    chk("post_rst_silent", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent button inputs (1..16).
REQ-002 SHALL have parameter COL_W, default 4, width of the shared column bus.
REQ-003 SHALL have parameter STABLE_CYCLES, default 270000, consecutive equal synchronized samples needed to accept a press or a release (>=2).
REQ-004 SHALL have parameter HOLD_CYCLES, default 2700000, db_out assertion length in HOLD mode (>=1).
REQ-005 SHALL have parameter MODE, default MODE_HOLD, db_out behaviour: MODE_PULSE, MODE_HOLD or MODE_LEVEL.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port button_in  input  CHANNELS  raw asynchronous buttons, 1 = pressed.
REQ-009 SHALL have port columnas  input  COL_W  shared column code, sampled at press acceptance.
REQ-010 SHALL have port db_level  output  CHANNELS  debounced button state per channel.
REQ-011 SHALL have port db_out  output  CHANNELS  per-channel output shaped by MODE.
REQ-012 SHALL have port col_latched  output  CHANNELS*COL_W  column code captured per channel; channel i occupies bits [i*COL_W +: COL_W].
REQ-013 SHALL have ports evt_valid (output 1), evt_ready (input 1), evt_chan (output clog2(CHANNELS), min 1), evt_col (output COL_W): press-event handshake.
REQ-014 SHALL have ports overflow (output 1, sticky lost-event flag) and clear_overflow (input 1).

Function
REQ-015 SHALL pass each button_in bit through a 2-flop synchronizer before all other logic.
REQ-016 SHALL run a per-channel FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-017 IDLE SHALL go to PRESS_WAIT on synchronized sample 1, with cnt=1.
REQ-018 PRESS_WAIT SHALL increment cnt on sample 1, return to IDLE with cnt=0 on sample 0, and go to PRESSED when cnt reaches STABLE_CYCLES.
REQ-019 PRESSED SHALL go to RELEASE_WAIT on sample 0, with cnt=1.
REQ-020 RELEASE_WAIT SHALL return to PRESSED on sample 1 and go to IDLE when cnt reaches STABLE_CYCLES.
REQ-021 db_level[i] SHALL be 1 exactly in PRESSED and RELEASE_WAIT; it rises STABLE_CYCLES+2 cycles after button_in goes high and stays high.
REQ-022 On entry to PRESSED, col_latched[i] SHALL load columnas and then hold until the next press acceptance, even if columnas changes.
REQ-023 MODE_PULSE: db_out[i] SHALL be high for one cycle on entry to PRESSED.
REQ-024 MODE_HOLD: db_out[i] SHALL be high for exactly HOLD_CYCLES cycles starting on entry to PRESSED, independent of release; there is no retrigger until the channel has returned to IDLE.
REQ-025 MODE_LEVEL: db_out[i] SHALL equal db_level[i].
REQ-026 Each press acceptance SHALL set pending[i]; setting it while pending[i] is already 1 SHALL set overflow.
REQ-027 The event register SHALL load the lowest-index pending channel when evt_valid=0, or when evt_valid&evt_ready in the same cycle; the loaded pending bit clears.
REQ-028 evt_valid SHALL hold until evt_valid&evt_ready, and evt_chan/evt_col SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-029 evt_col SHALL equal the column code latched at that channel's press.
REQ-030 A press accepted in the same cycle its channel's event is loaded SHALL re-set pending without overflow.
REQ-031 clear_overflow SHALL clear overflow the next cycle; a simultaneous new overflow wins.
REQ-032 Counters SHALL saturate at STABLE_CYCLES/HOLD_CYCLES and never wrap.

Reset
REQ-033 While reset=1, all of the following SHALL be 0 after the next edge: FSMs (IDLE), counters, synchronizers, pending, db_level, db_out, col_latched, evt_valid, evt_chan, evt_col and overflow.
REQ-034 Reset asserted mid-hold or mid-handshake SHALL abort with no event emitted afterward for the aborted press.

Structure
REQ-035 Package key_debounce_pkg SHALL hold the state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the mode enum (MODE_PULSE, MODE_HOLD, MODE_LEVEL).
REQ-036 Sub-module debounce_channel SHALL contain the synchronizer, FSM, counters, column latch and db_out shaping; it is instantiated CHANNELS times, and the top holds pending, arbiter, event register and overflow.
REQ-037 Counter widths SHALL be $clog2(max value + 1).

Verification (CHANNELS=4, COL_W=4, STABLE_CYCLES=6, HOLD_CYCLES=20, MODE_HOLD unless stated)
REQ-038 Clean press: ch0 high with columnas=0010 -> db_level[0] rises at cycle 8; db_out[0] high for 20 cycles; one event chan=0, col=0010.
REQ-039 Bounce: ch1 toggles 1,0,1,0 then stays low -> no db_level, no db_out, no event for 200 cycles.
REQ-040 Column freeze: ch2 press with 0100, then columnas=1000 while pressed -> col_latched ch2 = 0100, event col=0100.
REQ-041 Simultaneous: ch1 and ch3 accepted in the same cycle, evt_ready=0 for 5 cycles then 1 -> chan 1 is delivered first, then chan 3, and overflow=0.
REQ-042 Overflow: evt_ready=0, ch0 pressed, released, pressed again -> overflow=1; clear_overflow pulse -> overflow=0.
REQ-043 Modes: repeat REQ-038 with MODE_PULSE -> 1-cycle db_out; with MODE_LEVEL -> db_out equals db_level; reset at hold cycle 10 -> all outputs 0 the next cycle.
